// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI responder
//
// Contents:
//   DATA_W_DEFAULT  default frame width in bits
//   spi_state_e     responder FSM state encoding
//   MODE0..MODE3    SPI mode constants packed as {cpol, cpha}
package spi_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-flop synchronizer with rise/fall edge pulses
//
// Ports:
//   clk, rst_n  local clock, asynchronous active-low reset
//   din         asynchronous input
//   sync        synchronized level (2nd flop)
//   rise        one-cycle pulse when sync goes 0->1 (2nd vs 3rd flop)
//   fall        one-cycle pulse when sync goes 1->0 (2nd vs 3rd flop)
module spi_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh <= 3'b000;
    end else begin
      sh <= {sh[1:0], din};
    end
  end

  assign sync = sh[1];
  assign rise = sh[1] & ~sh[2];
  assign fall = ~sh[1] & sh[2];

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI responder, all four CPOL/CPHA modes, LSB first
//
// Ports:
//   clk, rst_n        local clock (>= 6x SCLK), asynchronous active-low reset
//   cpol, cpha        SPI mode, latched at frame start
//   slave_start       select from the master, active-high, asynchronous
//   SCLK, MOSI        serial clock and data from the master, asynchronous
//   MISO              serial data to the master, LSB first
//   tx_data, tx_load  write the transmit buffer
//   tx_ready          transmit buffer empty (copied into the shifter)
//   rx_data           last complete received frame
//   rx_valid          one-cycle pulse when rx_data updates
//   busy              frame in progress
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              slave_start,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic ss_sync, ss_rise, ss_fall;
  logic mosi_meta, mosi_sync;

  spi_sync_edge u_sclk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (SCLK),
    .sync  (sclk_sync),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge u_ss_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (slave_start),
    .sync  (ss_sync),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  // MOSI is taken from its 2nd flop, so it lines up with the SCLK edge
  // detected from the SCLK 2nd/3rd flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      mosi_meta <= MOSI;
      mosi_sync <= mosi_meta;
    end
  end

  spi_state_e        state;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] tx_buf;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] rx_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic              sclk_edge;
  logic              lead_edge;
  logic              trail_edge;
  logic              sample_edge;
  logic              shift_edge;

  // An edge is leading when SCLK has just left its idle level.
  always_comb begin
    sclk_edge   = sclk_rise | sclk_fall;
    lead_edge   = sclk_edge & (sclk_sync ^ mode_q[1]);
    trail_edge  = sclk_edge & ~(sclk_sync ^ mode_q[1]);
    sample_edge = mode_q[0] ? trail_edge : lead_edge;
    shift_edge  = mode_q[0] ? lead_edge  : trail_edge;
  end

  // New bit enters at the MSB so the first bit ends up at bit 0.
  assign rx_next = DATA_W'({mosi_sync, rx_shift} >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      mode_q   <= MODE0;
      tx_buf   <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      MISO     <= 1'b0;
      tx_ready <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          MISO <= 1'b0;
          if (ss_rise) begin
            state    <= ST_ACTIVE;
            busy     <= 1'b1;
            mode_q   <= {cpol, cpha};
            bit_cnt  <= '0;
            tx_ready <= 1'b1;
            if (!cpha) begin
              // Bit 0 must already be on MISO at the first (sampling) edge.
              MISO     <= tx_buf[0];
              tx_shift <= tx_buf >> 1;
            end else begin
              tx_shift <= tx_buf;
            end
          end
        end

        ST_ACTIVE: begin
          if (ss_fall) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            bit_cnt <= '0;
            MISO    <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_shift <= rx_next;
              if (bit_cnt == LAST_BIT) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                bit_cnt  <= '0;
                // Back-to-back frame: the following shift edge drives the
                // new bit 0, so the whole buffer is reloaded here.
                if (ss_sync) begin
                  tx_shift <= tx_buf;
                  tx_ready <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
            if (shift_edge) begin
              MISO     <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase

      // Placed last so a load coinciding with a buffer copy leaves
      // tx_ready low; the copy above already took the old buffer value.
      if (tx_load) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end
    end
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

Responder end of the team's SPI link: receives frames from the SPI master over SCLK/MOSI/slave_start and returns its own data on MISO. SCLK, MOSI and slave_start are oversampled in the local `clk` domain. Supports all four CPOL/CPHA modes with the master's LSB-first bit order. The block hands received bytes to local logic with a one-cycle valid pulse and accepts transmit bytes through a load/ready buffer.

## Interface
- DATA_W, 8, frame width in bits
- clk  in  1  system clock, ≥ 6× SCLK frequency
- rst_n  in  1  reset, asynchronous, active-low
- cpol  in  1  SCLK idle level; latched at frame start
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at frame start
- slave_start  in  1  select from the master, active-high, asynchronous to clk
- SCLK  in  1  serial clock from the master, asynchronous
- MOSI  in  1  serial data from the master, asynchronous
- MISO  out  1  serial data to the master, LSB first
- tx_data  in  DATA_W  next byte to send
- tx_load  in  1  write tx_data into the transmit buffer
- tx_ready  out  1  transmit buffer empty
- rx_data  out  DATA_W  last complete received frame
- rx_valid  out  1  one-cycle pulse when rx_data updates
- busy  out  1  frame in progress

## Operation
- Synchronization:
  - SCLK, MOSI and slave_start each pass through a 2-flop synchronizer.
  - SCLK edges are detected from the 2nd and 3rd flops.
- Leading edge is rising when cpol=0, falling when cpol=1.
- Sample edge:
  - cpha=0: sample on the leading edge, shift on the trailing edge.
  - cpha=1: shift on the leading edge, sample on the trailing edge.
- FSM states IDLE, ACTIVE.
- IDLE → ACTIVE on the synchronized slave_start rising. On that transition the block:
  - latches cpol and cpha;
  - copies the transmit buffer to the tx shift register and sets tx_ready=1;
  - clears the bit counter;
  - for cpha=0, drives tx bit 0 on MISO immediately.
- In ACTIVE:
  - Each sample edge shifts the synchronized MOSI into the rx shift register, LSB first, and increments the 0..DATA_W-1 counter.
  - Each shift edge drives the next tx bit. For cpha=1 the first leading edge drives bit 0.
- On the DATA_W-th sample edge:
  - rx_data ← rx shift register; rx_valid=1 for one cycle.
  - The counter wraps to 0.
  - If still selected, the next frame begins back-to-back: the tx shift register reloads from the buffer and tx_ready is set.
- ACTIVE → IDLE on slave_start deassertion:
  - A partial frame is discarded; no rx_valid is raised.
  - The counter clears and MISO=0.
- Transmit buffer:
  - tx_load writes it and clears tx_ready.
  - tx_load while tx_ready=0 overwrites the pending value.
  - If the buffer is not reloaded, the next frame resends the last loaded value.
- Simultaneous tx_load and buffer copy: the copy takes the old buffer value, the new value is stored, and tx_ready stays 0.
- cpol/cpha changes while busy are ignored until the next frame start.

## Timing
- Reset values: MISO=0, rx_data=0, rx_valid=0, busy=0, tx_ready=1, FSM=IDLE, buffer=0.
- Reset asserted mid-frame aborts the frame immediately, with no rx_valid.
- Input-to-detect latency: 3 clk cycles from an SCLK pin edge to internal edge detection.
- MISO update lands 1 clk cycle after the shift edge is detected.
- rx_valid is high in the cycle after the final sample edge is detected.
- busy rises 1 cycle after synchronized slave_start rises and falls 1 cycle after it falls.
- Requirements on the master:
  - SCLK high and low phases each ≥ 3 clk periods.
  - slave_start setup ≥ 3 clk periods before the first SCLK edge.

## Structure
- Shared `spi_pkg` holds:
  - FSM state encoding (IDLE, ACTIVE);
  - mode constants MODE0..MODE3 as {cpol,cpha};
  - default DATA_W.
- One sub-module, `spi_sync_edge`: 2-flop synchronizer plus rise/fall pulse outputs. Instantiate it for SCLK and slave_start; MOSI uses the synchronizer path only.

## Test plan
- Mode 0: master sends 0xA5, tx buffer 0xBA → rx_data=0xA5 with one rx_valid pulse; master receives 0xBA; tx_ready=1 after frame start.
- Modes 1, 2, 3 in turn with master 0x3C, slave 0xC3 → correct bytes in both directions; MISO bit 0 appears before the first SCLK edge only when cpha=0.
- Two back-to-back frames under a held select (0x11 then 0x22 in, buffer reloaded with 0x55 between frames) → two rx_valid pulses with 0x11 and 0x22; master receives old value, then 0x55.
- Deselect after 4 bits of 0xF0 → no rx_valid, rx_data unchanged, busy=0; the next full frame 0x0F is received correctly.
- rst_n pulsed low mid-frame → all outputs at reset values; a subsequent frame 0x81 completes correctly.
- No tx_load between two frames with buffer=0x6E → both frames return 0x6E.
